// File: rtl/priority_arbiter8.sv
// 8-requester arbiter: grants one owner at a time and holds until done, request drop or hold budget.
// Optional build macro ROUND_ROBIN_EN switches fixed priority (req[7] highest) to a rotating pointer.
module priority_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       idle,
  output logic       timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_MAX   = 8'(MAX_HOLD);

  logic [1:0] state_r, state_s;
  logic [7:0] hold_cnt_r, hold_cnt_s;
  logic [7:0] gnt_r, gnt_s;
  logic [2:0] gnt_idx_r, gnt_idx_s;
  logic       gnt_valid_r, gnt_valid_s;
  logic       idle_r, idle_s;
  logic       timeout_r, timeout_s;
  logic [2:0] win_s;
  logic       at_limit_s;
  logic       end_s;

  // Highest set bit wins; later iterations overwrite earlier ones.
  function automatic logic [2:0] enc_fixed(input logic [7:0] r);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr_r;

  // Search downward from the pointer, wrapping mod 8; first hit wins.
  function automatic logic [2:0] enc_rr(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic [2:0] cand;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = p - 3'(i);
      if (!found && r[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Pointer moves just below the finishing owner so it ranks last next round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= 3'd7;
    end else if (state_r == ST_BUSY && end_s) begin
      ptr_r <= gnt_idx_r - 3'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign win_s = enc_rr(req, ptr_r);
`else
  assign win_s = enc_fixed(req);
`endif

  assign at_limit_s = (hold_cnt_r == HOLD_LIMIT);
  assign end_s      = done | ~req[gnt_idx_r] | at_limit_s;

  // Next-state and next-output computation for the IDLE/BUSY/RELEASE machine.
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = gnt_r;
    gnt_idx_s   = gnt_idx_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req != 8'h00) begin
          state_s     = ST_BUSY;
          hold_cnt_s  = 8'd0;
          gnt_s       = 8'h01 << win_s;
          gnt_idx_s   = win_s;
          gnt_valid_s = 1'b1;
        end else begin
          state_s     = ST_IDLE;
          gnt_s       = 8'h00;
          gnt_idx_s   = 3'd0;
          gnt_valid_s = 1'b0;
        end
      end
      ST_BUSY: begin
        if (end_s) begin
          state_s     = ST_RELEASE;
          hold_cnt_s  = 8'd0;
          gnt_s       = 8'h00;
          gnt_idx_s   = 3'd0;
          gnt_valid_s = 1'b0;
          // Only a pure budget expiry counts as a forced revoke.
          timeout_s   = at_limit_s & ~done & req[gnt_idx_r];
        end else if (hold_cnt_r == HOLD_MAX) begin
          hold_cnt_s  = hold_cnt_r;
        end else begin
          hold_cnt_s  = hold_cnt_r + 8'd1;
        end
      end
      ST_RELEASE: begin
        state_s     = ST_IDLE;
        gnt_s       = 8'h00;
        gnt_idx_s   = 3'd0;
        gnt_valid_s = 1'b0;
      end
      default: begin
        state_s     = ST_IDLE;
        hold_cnt_s  = 8'd0;
        gnt_s       = 8'h00;
        gnt_idx_s   = 3'd0;
        gnt_valid_s = 1'b0;
      end
    endcase
    idle_s = (state_s == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      hold_cnt_r  <= 8'd0;
      gnt_r       <= 8'h00;
      gnt_idx_r   <= 3'd0;
      gnt_valid_r <= 1'b0;
      idle_r      <= 1'b1;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_r       <= gnt_s;
      gnt_idx_r   <= gnt_idx_s;
      gnt_valid_r <= gnt_valid_s;
      idle_r      <= idle_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign idle      = idle_r;
  assign timeout   = timeout_r;

endmodule

// File: doc/priority_arbiter8.md
# priority_arbiter8

Sequential 8-requester arbiter built around the 8-to-3 priority encoding function. It samples eight request lines, grants one requester at a time, and holds the grant until the requester signals completion, withdraws its request, or exceeds a hold budget. It sits in front of any single shared resource in the lab designs, for example a bus or a shared register port. It drives both a one-hot grant and the encoded 3-bit index of the winner.

## Interface

Parameters:
- `MAX_HOLD`, default 16: maximum cycles a grant may stay asserted before forced revoke; legal range 1..255.

Ports:
- `clk`  input  1  system clock; everything is on the rising edge.
- `rst_n`  input  1  reset. One clock; reset is synchronous and active-low.
- `req`  input  8  request lines; `req[7]` has the highest fixed priority.
- `done`  input  1  current grant holder finished; sampled only in BUSY.
- `gnt`  output  8  one-hot grant, registered.
- `gnt_idx`  output  3  encoded index of the granted requester, registered.
- `gnt_valid`  output  1  high while `gnt` is non-zero.
- `idle`  output  1  high in the IDLE state.
- `timeout`  output  1  one-cycle pulse when a grant is force-revoked.

## Operation

The arbiter has three states: IDLE, BUSY and RELEASE. Reset enters IDLE.

IDLE:
- If `req` == 0, the arbiter stays in IDLE.
- Otherwise it priority-encodes `req` to index k, registers `gnt` = 1<<k and `gnt_idx` = k, clears the hold counter, and moves to BUSY.

BUSY:
- The hold counter increments every cycle and saturates at `MAX_HOLD`.
- The grant ends on the first cycle in which any of these is true: `done`=1, `req[gnt_idx]`=0, or the counter reaches `MAX_HOLD`-1 (the grant has been visible for `MAX_HOLD` cycles).
- When the grant ends, `gnt`, `gnt_idx` and `gnt_valid` clear and the state moves to RELEASE.
- `timeout` pulses only when the counter limit is the end cause and `done`=0 and the request is still high. If `done` and the limit coincide, `timeout` stays 0.
- New or higher-priority requests never preempt the current holder.

RELEASE:
- One dead cycle with all grants at 0, then IDLE. This guarantees a gap between consecutive owners.

Other rules:
- `gnt_idx` holds 0 whenever `gnt_valid`=0.
- A request that appears and drops while the arbiter is BUSY or in RELEASE is lost. Requesters must hold `req` until granted.

Reset values: `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `idle`=1, `timeout`=0, hold counter=0. Under `ROUND_ROBIN_EN` the priority pointer resets to 7.

## Timing

- Request to grant latency: `req` high in IDLE at edge n gives `gnt` visible after edge n+1.
- Release: `done` or `req` drop sampled at edge m gives `gnt` = 0 after edge m+1.
- Next grant: the earliest new grant is visible 2 cycles after release (RELEASE, then IDLE evaluation). The minimum turnaround is 3 cycles from the end cause to the next owner.
- `timeout` is asserted in the same cycle that `gnt` first reads 0.
- Reset mid-grant: `rst_n`=0 at any edge clears all outputs on that edge, with no RELEASE cycle.
- All outputs are glitch-free registered values; there are no combinational input-to-output paths.

## Configuration

`ROUND_ROBIN_EN`:
- Defined:
  - A 3-bit pointer p, reset to 7, records the search start.
  - The IDLE search order is p, p-1, ..., wrapping mod 8.
  - When a grant to k ends, p becomes (k-1) mod 8, so the last owner gets the lowest priority next.
- Undefined: fixed priority, `req[7]` highest down to `req[0]`; the pointer logic is not synthesized.

## Test plan

- Reset: hold `rst_n`=0 for 2 cycles with `req`=8'hFF. Required: `gnt`=0, `idle`=1 and `timeout`=0 throughout. One cycle after release from reset, `gnt`=8'h80 and `gnt_idx`=7.
- Priority: apply `req`=8'b1100_1001 (the I0/I3/I6/I7 pattern) and hold it. Required: `gnt`=8'h80 and `gnt_idx`=3'b111. Pulse `done` with `req`=8'b0100_1001. Required: `gnt`=0 for 2 cycles, then `gnt`=8'h40 and `gnt_idx`=6.
- Timeout with `MAX_HOLD`=4: hold `req`=8'h01 and keep `done`=0. Required: `gnt`=8'h01 for exactly 4 cycles, then `timeout`=1 for 1 cycle with `gnt`=0. Regrant to index 0 follows 2 cycles later.
- No preemption: grant to index 2, then raise `req[7]`. Required: `gnt` stays 8'h04 until `req[2]` drops. Then `gnt`=0 for 2 cycles, then 8'h80.
- Simultaneous end causes: assert `done`=1 on the cycle the counter hits the limit. Required: grant ends and `timeout` stays 0.
- `ROUND_ROBIN_EN`: hold `req`=8'hFF and pulse `done` on each grant. Required grant sequence: 7, 6, 5, 4, 3, 2, 1, 0, 7. Without the macro, the same stimulus gives 7 repeatedly.
